// File: rtl/simon_axil_regs_if.sv
// AXI4-Lite config bus carried between the Simon simulation top and its register slave.
interface simon_axil_regs_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport slave (
    input  araddr, arcache, arprot, arvalid, rready,
    input  awaddr, awcache, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arcache, arprot, arvalid, rready,
    output awaddr, awcache, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/simon_axil_regs.sv
// AXI4-Lite register slave for a Simon 64/128 core: key, data and control registers,
// core launch, result capture and sticky completion status.
module simon_axil_regs #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned BLOCK_WIDTH = 64,
  parameter int unsigned KEY_WIDTH   = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  simon_axil_regs_if.slave       axi_config,
  output logic                   core_start,
  output logic                   core_decrypt,
  output logic [KEY_WIDTH-1:0]   core_key,
  output logic [BLOCK_WIDTH-1:0] core_din,
  input  logic                   core_busy,
  input  logic                   core_done,
  input  logic [BLOCK_WIDTH-1:0] core_dout
);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  // Write channel holding registers
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  awready_q, wready_q;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q;

  // Read channel
  logic                  arready_q;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q;
  logic [1:0]            rresp_q;

  // Register file; the map is fixed at four key words and two data words
  logic                  decrypt_q;
  logic                  done_q;
  logic                  start_q;
  logic [3:0][31:0]      key_q;
  logic [1:0][31:0]      din_q;
  logic [1:0][31:0]      dout_q;

  logic                  aw_fire, w_fire, wr_fire, ar_fire;
  logic                  wr_err, rd_err;
  logic [3:0]            wr_idx, rd_idx;
  logic [31:0]           rd_data;

  assign aw_fire = axi_config.awvalid & awready_q;
  assign w_fire  = axi_config.wvalid & wready_q;
  assign ar_fire = axi_config.arvalid & arready_q;
  assign wr_fire = aw_held_q & w_held_q;
  assign wr_idx  = awaddr_q[5:2];
  assign rd_idx  = axi_config.araddr[5:2];

  always_comb begin
    aw_held_d = (aw_held_q | aw_fire) & ~wr_fire;
    w_held_d  = (w_held_q | w_fire) & ~wr_fire;
    bvalid_d  = wr_fire | (bvalid_q & ~axi_config.bready);
    rvalid_d  = ar_fire | (rvalid_q & ~axi_config.rready);
  end

  // Writable registers are locked while the core runs; STATUS only accepts DONE clears
  always_comb begin
    wr_err = 1'b0;
    unique case (wr_idx)
      4'd0, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: wr_err = core_busy;
      4'd1:                                     wr_err = wstrb_q[0] & wdata_q[0];
      default:                                  wr_err = 1'b1;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    unique case (rd_idx)
      4'd0:                      rd_data = {30'd0, decrypt_q, 1'b0};
      4'd1:                      rd_data = {30'd0, done_q, core_busy};
      4'd4, 4'd5, 4'd6, 4'd7:    rd_data = key_q[rd_idx[1:0]];
      4'd8, 4'd9:                rd_data = din_q[rd_idx[0]];
      4'd10, 4'd11:              rd_data = dout_q[rd_idx[0]];
      default:                   rd_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
      decrypt_q <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      key_q     <= '0;
      din_q     <= '0;
      dout_q    <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      awready_q <= ~aw_held_d & ~bvalid_d;
      wready_q  <= ~w_held_d & ~bvalid_d;
      arready_q <= ~rvalid_d;
      start_q   <= 1'b0;

      if (aw_fire) awaddr_q <= axi_config.awaddr;
      if (w_fire) begin
        wdata_q <= axi_config.wdata;
        wstrb_q <= axi_config.wstrb;
      end

      if (wr_fire) begin
        bresp_q <= wr_err ? RespSlverr : RespOkay;
        if (!wr_err) begin
          unique case (wr_idx)
            4'd0: begin
              if (wstrb_q[0]) begin
                decrypt_q <= wdata_q[1];
                if (wdata_q[0]) begin
                  start_q <= 1'b1;
                  done_q  <= 1'b0;
                end
              end
            end
            4'd1: begin
              if (wstrb_q[0] && wdata_q[1]) done_q <= 1'b0;
            end
            4'd4, 4'd5, 4'd6, 4'd7: begin
              for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) key_q[wr_idx[1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
              end
            end
            4'd8, 4'd9: begin
              for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) din_q[wr_idx[0]][8*i +: 8] <= wdata_q[8*i +: 8];
              end
            end
            default: ;
          endcase
        end
      end

      if (ar_fire) begin
        rdata_q <= rd_data;
        rresp_q <= rd_err ? RespSlverr : RespOkay;
      end

      // Placed last so a completion beats a same-cycle W1C or START clear
      if (core_done) begin
        dout_q <= core_dout;
        done_q <= 1'b1;
      end
    end
  end

  assign axi_config.awready = awready_q;
  assign axi_config.wready  = wready_q;
  assign axi_config.bvalid  = bvalid_q;
  assign axi_config.bresp   = bresp_q;
  assign axi_config.arready = arready_q;
  assign axi_config.rvalid  = rvalid_q;
  assign axi_config.rdata   = rdata_q;
  assign axi_config.rresp   = rresp_q;

  assign core_start   = start_q;
  assign core_decrypt = decrypt_q;
  assign core_key     = key_q;
  assign core_din     = din_q;

  logic unused_ok;
  assign unused_ok = ^{axi_config.arcache, axi_config.arprot, axi_config.awcache,
                       axi_config.awprot, axi_config.araddr[ADDR_WIDTH-1:6],
                       axi_config.araddr[1:0], awaddr_q[ADDR_WIDTH-1:6], awaddr_q[1:0]};
endmodule
